// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word carry-lookahead adder sequencer.
package cla_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CLA_N = 8;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } seq_state_e;

endpackage

// File: rtl/cla_nbits.sv
// Combinational n-bit carry-lookahead adder: every carry is a flat sum of
// generate terms gated by the propagate run above them, plus the carry-in term.
module cla_nbits #(
    parameter int n = 8
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n-1:0] g_s;
    logic [n-1:0] p_s;
    logic [n:0]   c_s;

    // Lookahead carry for each bit position.
    always_comb begin
        logic acc_v;
        logic term_v;
        g_s    = x & y;
        p_s    = x ^ y;
        c_s    = '0;
        c_s[0] = cin;
        for (int i = 0; i < n; i++) begin
            term_v = cin;
            for (int k = 0; k <= i; k++) begin
                term_v = term_v & p_s[k];
            end
            acc_v = term_v;
            for (int j = 0; j <= i; j++) begin
                term_v = g_s[j];
                for (int k = j + 1; k <= i; k++) begin
                    term_v = term_v & p_s[k];
                end
                acc_v = acc_v | term_v;
            end
            c_s[i+1] = acc_v;
        end
    end

    assign s    = p_s ^ c_s[n-1:0];
    assign cout = c_s[n];

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-precision adder: walks K chunks of n bits through one shared
// cla_nbits, feeding each chunk's carry-out into the next chunk.
module cla_multiword_seq
    import cla_pkg::*;
#(
    parameter int n = CLA_N,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n*K-1:0] a,
    input  logic [n*K-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [n*K-1:0] sum,
    output logic           cout,
    output logic           busy
);

    localparam int W  = n * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

    seq_state_e    state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [W-1:0]  sum_q,   sum_d;
    logic          cout_q,  cout_d;

    logic [n-1:0]  x_s;
    logic [n-1:0]  y_s;
    logic [n-1:0]  s_s;
    logic          cout_cla_s;

    assign x_s = a_q[int'(idx_q)*n +: n];
    assign y_s = b_q[int'(idx_q)*n +: n];

    cla_nbits #(.n(n)) u_cla (
        .x    (x_s),
        .y    (y_s),
        .cin  (carry_q),
        .s    (s_s),
        .cout (cout_cla_s)
    );

    // Next-state, chunk sequencing and result accumulation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*n +: n] = s_s;
                carry_d = cout_cla_s;
                if (idx_q == IDX_LAST) begin
                    cout_d  = cout_cla_s;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, operand and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake flags are suppressed while reset is asserted.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = rst_n && (state_q == DONE);
    assign busy      = rst_n && ((state_q == RUN) || (state_q == DONE));
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Scoreboard bench for cla_multiword_seq (n=8, K=4) with directed vectors.
module tb_cla_multiword_seq;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic         cout;
    logic [W-1:0] sum;

    logic [W:0] exp_q[$];
    int         hs_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    cla_multiword_seq #(.n(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted result is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h with empty scoreboard", {cout, sum});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", {31'd0, cout, sum}, {31'd0, e});
                hs_q.push_back(cyc);
            end
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W:0] ev, input bit push);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed %0b", in_ready);
        end
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        if (push) exp_q.push_back(ev);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state.
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("idle_in_ready", in_ready, 1);

        // Test 1: zero operands, plus latency of K edges.
        issue(32'h0, 32'h0, 1'b0, 33'h0_0000_0000, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat_not_yet", out_valid, 0);
        chk("run_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("lat_k_edges", out_valid, 1);
        drain();

        // Test 2: carry from chunk 0 into chunk 1.
        issue(32'h93, 32'hDB, 1'b1, {1'b0, 32'h0000_016F}, 1'b1);
        drain();

        // Test 4: stall in DONE, extra in_valid must be ignored.
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789}, 1'b1);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, 32'h2345_6789);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_busy", busy, 1);
            a = 32'h1;
            b = 32'h1;
            in_valid = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_idle_busy", busy, 0);
        chk("release_idle_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        drain();

        // Test 3: carry ripples through every chunk.
        issue(32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0}, 1'b1);
        drain();
        chk("hold_cout_idle", cout, 1);
        issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, {1'b0, 32'hFFFF_FFFF}, 1'b1);
        drain();
        issue(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, {1'b0, 32'h0001_FFFF}, 1'b1);
        drain();
        issue(32'h8000_0001, 32'h8000_0000, 1'b0, {1'b1, 32'h0000_0001}, 1'b1);
        drain();

        // Test 5: reset while idx is 2 discards the operation.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_valid", out_valid, 0);
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_busy", busy, 0);
        chk("postrst_sum", sum, 0);
        chk("postrst_cout", cout, 0);
        repeat (8) @(negedge clk);
        chk("postrst_no_valid", out_valid, 0);
        issue(32'hFF, 32'h01, 1'b0, {1'b0, 32'h0000_0100}, 1'b1);
        drain();

        // Test 6: back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        a = 32'h8000_0000;
        b = 32'h8000_0000;
        cin = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back({1'b1, 32'h0});
        @(posedge clk);
        #1;
        a = 32'd5;
        b = 32'd49;
        exp_q.push_back({1'b0, 32'h36});
        t = 0;
        @(negedge clk);
        while (in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        if (hs_q.size() >= 2) begin
            chk("b2b_spacing", hs_q[hs_q.size()-1] - hs_q[hs_q.size()-2], K + 2);
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_spacing: only %0d handshakes seen", hs_q.size());
        end
        repeat (10) @(negedge clk);
        chk("no_extra_op", busy, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
